dut_host_init: RTL and testbench

- Initiator-side counterpart of the din/dout/len/cfg method interface: drives the enable-qualified inputs of the byte-stream dut and consumes its ready-qualified outputs.
- Takes one transaction request: a cfg write, a length, then a payload from an upstream byte source.
- Streams the payload into din while draining an equal number of dout bytes to a downstream sink.
- Finishes with a cfg read of a status register and returns the result.

---
 rtl/dut_host_init.sv | 251 +++++++++++++++++++++++++
 tb/tb_dut_host_init.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_host_init.sv
// dut_host_init -- initiator for the din/dout/len/cfg byte-stream method interface.
//
// One request runs in four phases:
//   1. a cfg write of the request address and data,
//   2. a len transfer,
//   3. the payload streamed into din while the same number of dout bytes is
//      drained to the sink,
//   4. a cfg read of STATUS_ADDR, whose result is returned on resp_data.
//
// Every x_en is qualified combinationally by its x_rdy, so a transfer happens
// exactly when x_en is high.
//
// Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   req_*               transaction request (valid/ready, len, cfg addr/data)
//   src_*               upstream payload byte source (valid/ready)
//   snk_*               drained dout bytes, one-cycle valid pulse per byte
//   resp_*              completion pulse, status word, abort flag
//   din_*, dout_*,
//   len_*, cfg_*        method interface toward the byte-stream dut
//
// Optional feature (macro DUT_HOST_WDOG_EN):
//   A stall watchdog. WDOG_CYCLES consecutive cycles without a transfer
//   abort the transaction with resp_err = 1 and resp_data = {24'h0, rcvd}.
//   Without the macro resp_err is tied low and the host waits indefinitely.
module dut_host_init #(
  parameter logic [7:0]  STATUS_ADDR = 8'h00,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_len,
  input  logic [7:0]  req_cfg_addr,
  input  logic [31:0] req_cfg_data,
  input  logic [7:0]  src_value,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [7:0]  snk_value,
  output logic        snk_valid,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [7:0]  din_value,
  output logic        din_en,
  input  logic        din_rdy,
  output logic        dout_en,
  input  logic [7:0]  dout_value,
  input  logic        dout_rdy,
  output logic [7:0]  len_value,
  output logic        len_en,
  input  logic        len_rdy,
  output logic [7:0]  cfg_address,
  output logic [31:0] cfg_data_in,
  output logic        cfg_op,
  output logic        cfg_en,
  input  logic [31:0] cfg_data_out,
  input  logic        cfg_rdy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CFGW = 3'd1,
    S_LEN  = 3'd2,
    S_STRM = 3'd3,
    S_STAT = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  sent_q, sent_d;
  logic [7:0]  rcvd_q, rcvd_d;
  logic [7:0]  snk_value_q, snk_value_d;
  logic        snk_valid_q, snk_valid_d;
  logic [31:0] resp_data_q, resp_data_d;

`ifdef DUT_HOST_WDOG_EN
  localparam int unsigned STALL_W = $clog2(WDOG_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               resp_err_q, resp_err_d;
  logic               stalled_s;
`endif

  // Next-state, datapath and combinationally qualified method enables.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sent_d      = sent_q;
    rcvd_d      = rcvd_q;
    resp_data_d = resp_data_q;
    req_ready   = 1'b0;
    src_ready   = 1'b0;
    din_en      = 1'b0;
    dout_en     = 1'b0;
    len_en      = 1'b0;
    cfg_en      = 1'b0;
    cfg_op      = 1'b0;
    cfg_address = addr_q;
    cfg_data_in = wdata_q;
    din_value   = src_value;
    len_value   = len_q;
`ifdef DUT_HOST_WDOG_EN
    resp_err_d  = resp_err_q;
    stall_d     = stall_q;
    stalled_s   = 1'b0;
`endif

    // RST_N gates every handshake output so a reset cycle drops them at once.
    case (state_q)
      S_IDLE: begin
        req_ready = RST_N;
        if (req_valid) begin
          len_d   = req_len;
          addr_d  = req_cfg_addr;
          wdata_d = req_cfg_data;
          sent_d  = 8'd0;
          rcvd_d  = 8'd0;
          state_d = S_CFGW;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CFGW: begin
        cfg_op = 1'b1;
        cfg_en = cfg_rdy & RST_N;
        if (cfg_en) begin
          state_d = S_LEN;
        end else begin
          state_d = S_CFGW;
        end
      end
      S_LEN: begin
        len_en = len_rdy & RST_N;
        if (len_en) begin
          state_d = (len_q != 8'd0) ? S_STRM : S_STAT;
        end else begin
          state_d = S_LEN;
        end
      end
      S_STRM: begin
        // The compare against len precedes the increment, so neither counter can wrap.
        din_en    = src_valid & din_rdy & (sent_q < len_q) & RST_N;
        src_ready = din_en;
        dout_en   = dout_rdy & (rcvd_q < len_q) & RST_N;
        sent_d    = sent_q + {7'd0, din_en};
        rcvd_d    = rcvd_q + {7'd0, dout_en};
        // Use the post-increment counts so STAT follows the final transfer directly.
        if ((sent_d == len_q) && (rcvd_d == len_q)) begin
          state_d = S_STAT;
        end else begin
          state_d = S_STRM;
        end
      end
      S_STAT: begin
        cfg_op      = 1'b0;
        cfg_address = STATUS_ADDR;
        cfg_data_in = 32'h0000_0000;
        cfg_en      = cfg_rdy & RST_N;
        if (cfg_en) begin
          resp_data_d = cfg_data_out;
`ifdef DUT_HOST_WDOG_EN
          resp_err_d  = 1'b0;
`endif
          state_d     = S_RESP;
        end else begin
          state_d = S_STAT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef DUT_HOST_WDOG_EN
    // A transfer always coincides with either a state change or STRM progress,
    // so clearing on "not stalled" covers both the transfer and state-change cases.
    stalled_s = ((state_q == S_CFGW) || (state_q == S_LEN) ||
                 (state_q == S_STRM) || (state_q == S_STAT)) &&
                !(cfg_en || len_en || din_en || dout_en);
    if (!stalled_s) begin
      stall_d = '0;
    end else if (stall_q == STALL_W'(WDOG_CYCLES - 1)) begin
      stall_d     = '0;
      state_d     = S_RESP;
      resp_err_d  = 1'b1;
      resp_data_d = {24'h00_0000, rcvd_q};
    end else begin
      stall_d = stall_q + STALL_W'(1);
    end
`endif
  end

  // Sink pipeline: register each drained dout byte and pulse snk_valid one cycle later.
  always_comb begin
    snk_valid_d = dout_en;
    snk_value_d = dout_en ? dout_value : snk_value_q;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      addr_q      <= 8'd0;
      wdata_q     <= 32'h0000_0000;
      sent_q      <= 8'd0;
      rcvd_q      <= 8'd0;
      snk_value_q <= 8'd0;
      snk_valid_q <= 1'b0;
      resp_data_q <= 32'h0000_0000;
`ifdef DUT_HOST_WDOG_EN
      stall_q     <= '0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sent_q      <= sent_d;
      rcvd_q      <= rcvd_d;
      snk_value_q <= snk_value_d;
      snk_valid_q <= snk_valid_d;
      resp_data_q <= resp_data_d;
`ifdef DUT_HOST_WDOG_EN
      stall_q     <= stall_d;
      resp_err_q  <= resp_err_d;
`endif
    end
  end

  assign snk_value  = snk_value_q;
  assign snk_valid  = snk_valid_q;
  assign resp_valid = (state_q == S_RESP) & RST_N;
  assign resp_data  = resp_data_q;
`ifdef DUT_HOST_WDOG_EN
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dut_host_init.sv
// Directed testbench for dut_host_init. The bench plays the byte-stream dut
// (ready inputs, dout bytes 8'h80 + n, status word), an upstream payload
// source and the sink. A negedge monitor logs every transfer it observes.
module tb_dut_host_init;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_len = 8'd0;
  logic [7:0]  req_cfg_addr = 8'd0;
  logic [31:0] req_cfg_data = 32'h0;
  logic [7:0]  src_value = 8'd0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [7:0]  snk_value;
  logic        snk_valid;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [7:0]  din_value;
  logic        din_en;
  logic        din_rdy = 1'b0;
  logic        dout_en;
  logic [7:0]  dout_value = 8'd0;
  logic        dout_rdy = 1'b0;
  logic [7:0]  len_value;
  logic        len_en;
  logic        len_rdy = 1'b0;
  logic [7:0]  cfg_address;
  logic [31:0] cfg_data_in;
  logic        cfg_op;
  logic        cfg_en;
  logic [31:0] cfg_data_out = 32'h0;
  logic        cfg_rdy = 1'b0;

  dut_host_init #(.STATUS_ADDR(8'h00), .WDOG_CYCLES(16)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .req_cfg_addr(req_cfg_addr), .req_cfg_data(req_cfg_data),
    .src_value(src_value), .src_valid(src_valid), .src_ready(src_ready),
    .snk_value(snk_value), .snk_valid(snk_valid),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
    .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment controls
  bit          rand_mode = 1'b0;
  bit          fix_dout_rdy = 1'b1;
  logic [31:0] stat_word = 32'h0;
  logic [7:0]  payload [256];
  int          src_idx = 0;
  int          dout_cnt = 0;

  // Environment: drive ready/valid and data a little after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (rand_mode) begin
      din_rdy   = ($urandom_range(0, 3) != 0);
      dout_rdy  = ($urandom_range(0, 3) != 0);
      src_valid = ($urandom_range(0, 3) != 0);
      len_rdy   = ($urandom_range(0, 1) != 0);
      cfg_rdy   = ($urandom_range(0, 1) != 0);
    end else begin
      din_rdy   = 1'b1;
      dout_rdy  = fix_dout_rdy;
      src_valid = 1'b1;
      len_rdy   = 1'b1;
      cfg_rdy   = 1'b1;
    end
    src_value    = payload[src_idx[7:0]];
    dout_value   = 8'h80 + 8'(dout_cnt);
    cfg_data_out = stat_word;
  end

  // Monitor logs
  logic [7:0]  din_got [$];
  logic [7:0]  snk_got [$];
  logic [7:0]  len_got [$];
  logic [40:0] cfg_got [$];
  int          resp_cnt = 0, din_en_cnt = 0, dout_en_cnt = 0, viol = 0;
  logic [31:0] resp_data_seen = 32'h0;
  logic        resp_err_seen = 1'b0;

  // Monitor: sample handshakes mid-cycle, log transfers, count protocol violations.
  always @(negedge CLK) begin
    if ((din_en && !din_rdy) || (dout_en && !dout_rdy) || (len_en && !len_rdy) ||
        (cfg_en && !cfg_rdy) || (src_ready !== din_en) || (din_en && !src_valid)) viol++;
    if (din_en) din_en_cnt++;
    if (dout_en) dout_en_cnt++;
    if (din_en && din_rdy) begin
      din_got.push_back(din_value);
      src_idx++;
    end
    if (dout_en && dout_rdy) dout_cnt++;
    if (snk_valid) snk_got.push_back(snk_value);
    if (cfg_en && cfg_rdy) cfg_got.push_back({cfg_op, cfg_address, cfg_data_in});
    if (len_en && len_rdy) len_got.push_back(len_value);
    if (resp_valid) begin
      resp_cnt++;
      resp_data_seen = resp_data;
      resp_err_seen  = resp_err;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_logs();
    din_got.delete(); snk_got.delete(); len_got.delete(); cfg_got.delete();
    resp_cnt = 0; din_en_cnt = 0; dout_en_cnt = 0; viol = 0;
    src_idx = 0; dout_cnt = 0;
  endtask

  task automatic do_req(input logic [7:0] l, input logic [7:0] a, input logic [31:0] d);
    req_len = l; req_cfg_addr = a; req_cfg_data = d; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output bit got);
    for (int i = 0; i < budget && resp_cnt == 0; i++) step();
    got = (resp_cnt != 0);
    step();
  endtask

  bit got;
  int errs;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_din_en", din_en, 1'b0);
    chk("rst_dout_en", dout_en, 1'b0);
    chk("rst_len_en", len_en, 1'b0);
    chk("rst_cfg_en", cfg_en, 1'b0);
    chk("rst_src_ready", src_ready, 1'b0);
    chk("rst_snk_valid", snk_valid, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    RST_N = 1'b1;
    #1;
    chk("idle_req_ready", req_ready, 1'b1);
    step();

    // Test 1: len=4, everything ready
    clear_logs();
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
    stat_word = 32'hDEAD_0001;
    do_req(8'd4, 8'h04, 32'hA5A5_0001);
    wait_resp(200, got);
    chk("t1_resp_seen", got, 1'b1);
    chk("t1_cfg_cnt", cfg_got.size(), 32'd2);
    chk("t1_cfgw_op_addr", cfg_got[0][40:32], {1'b1, 8'h04});
    chk("t1_cfgw_data", cfg_got[0][31:0], 32'hA5A5_0001);
    chk("t1_cfgr_op_addr", cfg_got[1][40:32], {1'b0, 8'h00});
    chk("t1_len_cnt", len_got.size(), 32'd1);
    chk("t1_len_val", len_got[0], 8'd4);
    chk("t1_din_cnt", din_got.size(), 32'd4);
    chk("t1_din0", din_got[0], 8'h11);
    chk("t1_din1", din_got[1], 8'h22);
    chk("t1_din2", din_got[2], 8'h33);
    chk("t1_din3", din_got[3], 8'h44);
    chk("t1_snk_cnt", snk_got.size(), 32'd4);
    chk("t1_snk0", snk_got[0], 8'h80);
    chk("t1_snk3", snk_got[3], 8'h83);
    chk("t1_resp_data", resp_data_seen, 32'hDEAD_0001);
    chk("t1_resp_err", resp_err_seen, 1'b0);
    chk("t1_resp_cnt", resp_cnt, 32'd1);
    chk("t1_viol", viol, 32'd0);
    stat_word = 32'h1111_1111;
    repeat (3) step();
    chk("t1_resp_hold", resp_data, 32'hDEAD_0001);
    chk("t1_idle_ready", req_ready, 1'b1);

    // Test 2: len=0 skips streaming
    clear_logs();
    stat_word = 32'h0000_BEEF;
    do_req(8'd0, 8'h10, 32'h1234_5678);
    wait_resp(200, got);
    chk("t2_resp_seen", got, 1'b1);
    chk("t2_cfg_cnt", cfg_got.size(), 32'd2);
    chk("t2_cfgw_data", cfg_got[0][31:0], 32'h1234_5678);
    chk("t2_len_val", len_got[0], 8'd0);
    chk("t2_din_en_cnt", din_en_cnt, 32'd0);
    chk("t2_dout_en_cnt", dout_en_cnt, 32'd0);
    chk("t2_resp_data", resp_data_seen, 32'h0000_BEEF);
    chk("t2_viol", viol, 32'd0);

    // Test 3: len=255 with random gaps on every handshake
    clear_logs();
    for (int i = 0; i < 256; i++) payload[i] = 8'(i * 7 + 3);
    stat_word = 32'h5A5A_00FF;
    rand_mode = 1'b1;
    do_req(8'd255, 8'h20, 32'hCAFE_F00D);
    wait_resp(20000, got);
    chk("t3_resp_seen", got, 1'b1);
    chk("t3_din_cnt", din_got.size(), 32'd255);
    errs = 0;
    for (int i = 0; i < din_got.size(); i++) if (din_got[i] !== 8'(i * 7 + 3)) errs++;
    chk("t3_din_order", errs, 32'd0);
    chk("t3_snk_cnt", snk_got.size(), 32'd255);
    errs = 0;
    for (int i = 0; i < snk_got.size(); i++) if (snk_got[i] !== 8'(8'h80 + i)) errs++;
    chk("t3_snk_order", errs, 32'd0);
    chk("t3_len_val", len_got[0], 8'd255);
    chk("t3_resp_data", resp_data_seen, 32'h5A5A_00FF);
    repeat (50) step();
    chk("t3_din_stop", din_en_cnt, 32'd255);
    chk("t3_dout_stop", dout_en_cnt, 32'd255);
    chk("t3_viol", viol, 32'd0);
    rand_mode = 1'b0;
    step();

    // Test 4: reset after 2 of 5 bytes, then a clean transaction
    clear_logs();
    for (int i = 0; i < 5; i++) payload[i] = 8'(8'hA1 + i);
    stat_word = 32'h0000_4444;
    do_req(8'd5, 8'h30, 32'h0000_0005);
    for (int i = 0; i < 100 && din_got.size() < 2; i++) step();
    chk("t4_two_sent", din_got.size(), 32'd2);
    RST_N = 1'b0;
    #1;
    chk("t4_rst_din_en", din_en, 1'b0);
    chk("t4_rst_dout_en", dout_en, 1'b0);
    chk("t4_rst_src_ready", src_ready, 1'b0);
    chk("t4_rst_cfg_en", cfg_en | len_en, 1'b0);
    chk("t4_rst_req_ready", req_ready, 1'b0);
    step();
    RST_N = 1'b1;
    #1;
    chk("t4_post_req_ready", req_ready, 1'b1);
    chk("t4_post_snk_valid", snk_valid, 1'b0);
    chk("t4_post_resp_data", resp_data, 32'h0);
    chk("t4_no_extra_din", din_got.size(), 32'd2);
    step();
    clear_logs();
    do_req(8'd5, 8'h31, 32'h0000_0006);
    wait_resp(200, got);
    chk("t4_resp_seen", got, 1'b1);
    chk("t4_din_cnt", din_got.size(), 32'd5);
    errs = 0;
    for (int i = 0; i < din_got.size(); i++) if (din_got[i] !== 8'(8'hA1 + i)) errs++;
    chk("t4_din_order", errs, 32'd0);
    chk("t4_snk_cnt", snk_got.size(), 32'd5);
    chk("t4_resp_data", resp_data_seen, 32'h0000_4444);
    chk("t4_resp_cnt", resp_cnt, 32'd1);

    // Test 5: dout never ready
    clear_logs();
    payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03;
    stat_word = 32'h0000_7777;
    fix_dout_rdy = 1'b0;
    step();
    do_req(8'd3, 8'h40, 32'h0000_0003);
`ifdef DUT_HOST_WDOG_EN
    wait_resp(200, got);
    chk("t5_wdog_resp_seen", got, 1'b1);
    chk("t5_wdog_err", resp_err_seen, 1'b1);
    chk("t5_wdog_data", resp_data_seen, 32'h0);
    chk("t5_wdog_din_cnt", din_got.size(), 32'd3);
    chk("t5_wdog_idle", req_ready, 1'b1);
`else
    repeat (1000) step();
    chk("t5_no_resp", resp_cnt, 32'd0);
    chk("t5_din_cnt", din_got.size(), 32'd3);
    chk("t5_dout_en_cnt", dout_en_cnt, 32'd0);
    chk("t5_stuck", req_ready, 1'b0);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    #1;
    chk("t5_recover_ready", req_ready, 1'b1);
`endif
    fix_dout_rdy = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
